// File: rtl/mmu_fifo_pkg.sv
// Shared types and sizing for the MMU FIFO read-side stream controller.
package mmu_fifo_pkg;

    typedef enum logic {
        FSR_RUN   = 1'b0,
        FSR_FLUSH = 1'b1
    } fsr_state_e;

    localparam int FSR_BUF_DEPTH = 2;
    localparam int FSR_OCC_W     = 2;

endpackage

// File: rtl/fifo_stream_reader_if.sv
// FIFO read port plus downstream valid/ready stream, as seen by fifo_stream_reader.
interface fifo_stream_reader_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_pop_data;
    logic                  fifo_pop;
    logic                  o_valid;
    logic                  i_ready;
    logic [DATA_WIDTH-1:0] o_data;

    // master is the reader block; slave is the FIFO/consumer environment around it
    modport master (
        input  fifo_empty, fifo_pop_data, i_ready,
        output fifo_pop, o_valid, o_data
    );

    modport slave (
        output fifo_empty, fifo_pop_data, i_ready,
        input  fifo_pop, o_valid, o_data
    );
endinterface

// File: rtl/fifo_stream_reader_skid_buf.sv
// fsr_skid_buf: 2-entry in-order output buffer with push, pop and clear.
module fsr_skid_buf
    import mmu_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic                  clear_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [FSR_OCC_W-1:0]  occ_o,
    output logic [DATA_WIDTH-1:0] head_o
);

    logic [DATA_WIDTH-1:0] ent_q [FSR_BUF_DEPTH];
    logic [DATA_WIDTH-1:0] ent_d [FSR_BUF_DEPTH];
    logic [FSR_OCC_W-1:0]  occ_q;
    logic [FSR_OCC_W-1:0]  occ_d;

    // Entry 0 is always the head, so a pop shifts entry 1 down.
    always_comb begin
        ent_d = ent_q;
        occ_d = occ_q;
        if (clear_i) begin
            occ_d = '0;
        end else begin
            case ({push_i, pop_i})
                2'b10: begin
                    if (occ_q < FSR_OCC_W'(FSR_BUF_DEPTH)) begin
                        ent_d[occ_q[0]] = data_i;
                        occ_d           = occ_q + 2'd1;
                    end
                end
                2'b01: begin
                    if (occ_q != '0) begin
                        ent_d[0] = ent_q[1];
                        occ_d    = occ_q - 2'd1;
                    end
                end
                2'b11: begin
                    if (occ_q == 2'd0) begin
                        ent_d[0] = data_i;
                        occ_d    = 2'd1;
                    end else if (occ_q == 2'd1) begin
                        ent_d[0] = data_i;
                    end else begin
                        ent_d[0] = ent_q[1];
                        ent_d[1] = data_i;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q <= '0;
            for (int i = 0; i < FSR_BUF_DEPTH; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            occ_q <= occ_d;
            for (int i = 0; i < FSR_BUF_DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
        end
    end

    assign occ_o  = occ_q;
    assign head_o = ent_q[0];

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side controller: FWFT FIFO -> registered valid/ready stream, with flush.
// Define FIFO_STREAM_READER_STATS_EN to enable the beat/drop statistics counters.
module fifo_stream_reader
    import mmu_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    fifo_stream_reader_if.master  bus,
    input  logic                  i_flush,
    output logic                  o_flush_done,
    output logic [CNT_WIDTH-1:0]  o_beat_cnt,
    output logic [CNT_WIDTH-1:0]  o_drop_cnt
);

    localparam logic [0:0] ST_RUN   = FSR_RUN;
    localparam logic [0:0] ST_FLUSH = FSR_FLUSH;

    logic [0:0]            state_q, state_d;
    logic                  flush_done_q, flush_done_d;
    logic [FSR_OCC_W-1:0]  occ;
    logic [DATA_WIDTH-1:0] head;
    logic                  inRun;
    logic                  valid;
    logic                  handshake;
    logic                  popReq;

    assign inRun     = (state_q == ST_RUN);
    assign valid     = inRun && (occ != '0);
    assign handshake = valid && bus.i_ready;

    // Pop decision looks only at registered occupancy so i_ready never reaches the FIFO.
    always_comb begin
        popReq = 1'b0;
        if (!i_rst) begin
            if (inRun) begin
                popReq = !bus.fifo_empty && (occ < FSR_OCC_W'(FSR_BUF_DEPTH)) && !i_flush;
            end else begin
                popReq = !bus.fifo_empty;
            end
        end
    end

    fsr_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk     (i_clk),
        .rst     (i_rst),
        .push_i  (popReq && inRun),
        .pop_i   (handshake),
        .clear_i (inRun && i_flush),
        .data_i  (bus.fifo_pop_data),
        .occ_o   (occ),
        .head_o  (head)
    );

    always_comb begin
        state_d      = state_q;
        flush_done_d = 1'b0;
        if (inRun) begin
            if (i_flush) begin
                state_d = ST_FLUSH;
            end
        end else if (!i_flush && bus.fifo_empty) begin
            state_d      = ST_RUN;
            flush_done_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= ST_RUN;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            flush_done_q <= flush_done_d;
        end
    end

`ifdef FIFO_STREAM_READER_STATS_EN
    logic [CNT_WIDTH-1:0] beat_q, beat_d;
    logic [CNT_WIDTH-1:0] drop_q, drop_d;
    logic [FSR_OCC_W-1:0] dropInc;

    // On the flush edge everything still buffered after this cycle's handshake is dropped.
    always_comb begin
        dropInc = '0;
        if (inRun) begin
            if (i_flush) begin
                dropInc = occ - {{(FSR_OCC_W-1){1'b0}}, handshake};
            end
        end else begin
            dropInc = {{(FSR_OCC_W-1){1'b0}}, popReq};
        end
        beat_d = beat_q + CNT_WIDTH'(handshake);
        drop_d = drop_q + CNT_WIDTH'(dropInc);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            beat_q <= '0;
            drop_q <= '0;
        end else begin
            beat_q <= beat_d;
            drop_q <= drop_d;
        end
    end

    assign o_beat_cnt = beat_q;
    assign o_drop_cnt = drop_q;
`else
    assign o_beat_cnt = '0;
    assign o_drop_cnt = '0;
`endif

    assign bus.fifo_pop = popReq;
    assign bus.o_valid  = valid;
    assign bus.o_data   = head;
    assign o_flush_done = flush_done_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader; a queue stands in for the FWFT FIFO.
module tb_fifo_stream_reader;

    localparam int DW = 32;
    localparam int CW = 16;
`ifdef FIFO_STREAM_READER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_flush;
    logic          o_flush_done;
    logic [CW-1:0] o_beat_cnt;
    logic [CW-1:0] o_drop_cnt;

    logic [DW-1:0] fifoQ [$];
    int            vectors     = 0;
    int            miscompares = 0;

    fifo_stream_reader_if #(.DATA_WIDTH(DW)) bus ();

    always #5 i_clk = ~i_clk;

    fifo_stream_reader #(
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .bus          (bus),
        .i_flush      (i_flush),
        .o_flush_done (o_flush_done),
        .o_beat_cnt   (o_beat_cnt),
        .o_drop_cnt   (o_drop_cnt)
    );

    task automatic refreshFifo();
        bus.fifo_empty    = (fifoQ.size() == 0);
        bus.fifo_pop_data = (fifoQ.size() == 0) ? '0 : fifoQ[0];
    endtask

    task automatic applyStimulus(input logic [DW-1:0] d);
        fifoQ.push_back(d);
        refreshFifo();
    endtask

    // Pop is sampled mid-cycle, applied to the FIFO model just after the edge.
    task automatic tick();
        logic wasPop;
        @(negedge i_clk);
        wasPop = bus.fifo_pop;
        @(posedge i_clk);
        #1;
        if (wasPop && fifoQ.size() > 0) void'(fifoQ.pop_front());
        refreshFifo();
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        i_rst       = 1'b1;
        i_flush     = 1'b0;
        bus.i_ready = 1'b0;
        refreshFifo();
        repeat (2) tick();
        checkOutput("rst_valid", bus.o_valid, 0);
        checkOutput("rst_data", bus.o_data, 0);
        checkOutput("rst_pop", bus.fifo_pop, 0);
        checkOutput("rst_done", o_flush_done, 0);
        checkOutput("rst_beat", o_beat_cnt, 0);
        checkOutput("rst_drop", o_drop_cnt, 0);
        i_rst = 1'b0;
        tick();

        // Streaming at full rate
        bus.i_ready = 1'b1;
        for (int i = 0; i < 4; i++) applyStimulus(32'hA0 + i);
        #1;
        checkOutput("s1_pop0", bus.fifo_pop, 1);
        checkOutput("s1_valid0", bus.o_valid, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput($sformatf("s1_valid%0d", i), bus.o_valid, 1);
            checkOutput($sformatf("s1_data%0d", i), bus.o_data, 32'hA0 + i);
            checkOutput($sformatf("s1_pop%0d", i + 1), bus.fifo_pop, (i < 3) ? 1 : 0);
        end
        tick();
        checkOutput("s1_idle", bus.o_valid, 0);
        checkOutput("s1_beat", o_beat_cnt, STATS ? 4 : 0);
        checkOutput("s1_drop", o_drop_cnt, 0);

        // Back-pressure: buffer fills to two, head held
        bus.i_ready = 1'b0;
        for (int i = 0; i < 5; i++) applyStimulus(32'hB0 + i);
        #1;
        checkOutput("s2_pop0", bus.fifo_pop, 1);
        tick();
        checkOutput("s2_valid1", bus.o_valid, 1);
        checkOutput("s2_data1", bus.o_data, 32'hB0);
        checkOutput("s2_pop1", bus.fifo_pop, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("s2_hold_data", bus.o_data, 32'hB0);
            checkOutput("s2_hold_pop", bus.fifo_pop, 0);
        end
        checkOutput("s2_fifo_left", fifoQ.size(), 3);
        bus.i_ready = 1'b1;
        #1;
        checkOutput("s2_rel_data", bus.o_data, 32'hB0);
        checkOutput("s2_rel_pop", bus.fifo_pop, 0);
        for (int i = 1; i < 5; i++) begin
            tick();
            checkOutput($sformatf("s2_valid%0d", i), bus.o_valid, 1);
            checkOutput($sformatf("s2_data%0d", i), bus.o_data, 32'hB0 + i);
        end
        tick();
        checkOutput("s2_idle", bus.o_valid, 0);
        checkOutput("s2_beat", o_beat_cnt, STATS ? 9 : 0);

        // Flush with a full buffer and a handshake on the flush edge
        bus.i_ready = 1'b0;
        for (int i = 0; i < 5; i++) applyStimulus(32'hC0 + i);
        tick();
        tick();
        bus.i_ready = 1'b1;
        i_flush     = 1'b1;
        #1;
        checkOutput("s3_pop_gated", bus.fifo_pop, 0);
        checkOutput("s3_head", bus.o_data, 32'hC0);
        tick();
        checkOutput("s3_valid_f1", bus.o_valid, 0);
        checkOutput("s3_beat", o_beat_cnt, STATS ? 10 : 0);
        checkOutput("s3_drop_f1", o_drop_cnt, STATS ? 1 : 0);
        checkOutput("s3_pop_f1", bus.fifo_pop, 1);
        tick();
        checkOutput("s3_drop_f2", o_drop_cnt, STATS ? 2 : 0);
        checkOutput("s3_valid_f2", bus.o_valid, 0);
        tick();
        checkOutput("s3_drop_f3", o_drop_cnt, STATS ? 3 : 0);
        tick();
        checkOutput("s3_drop_f4", o_drop_cnt, STATS ? 4 : 0);
        checkOutput("s3_pop_f4", bus.fifo_pop, 0);
        checkOutput("s3_done_held", o_flush_done, 0);

        // Pushes arriving while flush is held are drained and dropped
        applyStimulus(32'hD0);
        applyStimulus(32'hD1);
        #1;
        checkOutput("s4_pop", bus.fifo_pop, 1);
        checkOutput("s4_valid", bus.o_valid, 0);
        tick();
        checkOutput("s4_drop1", o_drop_cnt, STATS ? 5 : 0);
        checkOutput("s4_valid1", bus.o_valid, 0);
        tick();
        checkOutput("s4_drop2", o_drop_cnt, STATS ? 6 : 0);
        checkOutput("s4_pop_empty", bus.fifo_pop, 0);
        i_flush = 1'b0;
        #1;
        checkOutput("s4_done_early", o_flush_done, 0);
        tick();
        checkOutput("s4_done", o_flush_done, 1);
        checkOutput("s4_valid_done", bus.o_valid, 0);
        tick();
        checkOutput("s4_done_off", o_flush_done, 0);

        // Flush while idle
        i_flush = 1'b1;
        tick();
        checkOutput("s5_done_held", o_flush_done, 0);
        i_flush = 1'b0;
        tick();
        checkOutput("s5_done", o_flush_done, 1);
        checkOutput("s5_drop", o_drop_cnt, STATS ? 6 : 0);
        tick();
        checkOutput("s5_done_off", o_flush_done, 0);

        // Asynchronous reset mid-stream with a full buffer
        bus.i_ready = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus(32'hE0 + i);
        tick();
        tick();
        checkOutput("s6_pre_valid", bus.o_valid, 1);
        checkOutput("s6_pre_data", bus.o_data, 32'hE0);
        i_rst = 1'b1;
        #1;
        checkOutput("s6_rst_valid", bus.o_valid, 0);
        checkOutput("s6_rst_pop", bus.fifo_pop, 0);
        checkOutput("s6_rst_data", bus.o_data, 0);
        checkOutput("s6_rst_beat", o_beat_cnt, 0);
        tick();
        checkOutput("s6_rst_pop_hold", bus.fifo_pop, 0);
        i_rst       = 1'b0;
        bus.i_ready = 1'b1;
        #1;
        checkOutput("s6_pop", bus.fifo_pop, 1);
        checkOutput("s6_valid0", bus.o_valid, 0);
        tick();
        checkOutput("s6_valid1", bus.o_valid, 1);
        checkOutput("s6_data1", bus.o_data, 32'hE2);
        tick();
        checkOutput("s6_data2", bus.o_data, 32'hE3);
        tick();
        checkOutput("s6_idle", bus.o_valid, 0);
        checkOutput("s6_beat", o_beat_cnt, STATS ? 2 : 0);
        checkOutput("s6_drop", o_drop_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
- Read-side controller for the MMU synchronous FIFO.
- Consumes the FIFO's first-word-fall-through read interface (empty flag, combinational read data, pop strobe) and presents a registered valid/ready stream to a downstream consumer, e.g. a page-table-walk request port.
- Holds a 2-entry output buffer, so downstream ready never reaches the FIFO pop combinationally.
- Supports a flush that discards buffered and queued entries (used on TLB invalidate).

Parameters:
DATA_WIDTH, 32, width of FIFO entries and output data
CNT_WIDTH, 16, width of the statistics counters (wrap modulo 2^CNT_WIDTH)

Ports:
i_clk  input  1  clock, all state on rising edge
i_rst  input  1  asynchronous, active-high reset
fifo_empty  input  1  FIFO empty flag
fifo_pop_data  input  DATA_WIDTH  FIFO head entry; valid whenever fifo_empty=0
fifo_pop  output  1  pop strobe to FIFO; one entry removed per cycle when high
i_flush  input  1  level request: discard all buffered and queued entries
o_valid  output  1  output entry valid
i_ready  input  1  downstream accepts; transfer when o_valid & i_ready
o_data  output  DATA_WIDTH  output entry (oldest buffered)
o_flush_done  output  1  one-cycle pulse when flush completes
o_beat_cnt  output  CNT_WIDTH  entries delivered downstream (feature-gated)
o_drop_cnt  output  CNT_WIDTH  entries discarded by flush (feature-gated)

Behaviour:
- Reset values while i_rst is high:
  - state=RUN, occupancy=0, o_valid=0, o_data=0, o_flush_done=0, counters=0.
  - fifo_pop forced 0 for as long as i_rst is high.
- Reset mid-operation discards buffered entries. FIFO contents are untouched (the FIFO has its own reset).
- Buffer: 2-entry, in-order. Occupancy occ is in 0..2. o_valid = (occ != 0). o_data = head entry.
- State RUN:
  - fifo_pop = !fifo_empty & (occ < 2) & !i_flush.
  - fifo_pop uses only registered occ, never i_ready.
  - On a pop, fifo_pop_data is captured at the same edge.
- Latency: FIFO goes non-empty in cycle N → o_valid=1 in cycle N+1 with that entry.
- Throughput: 1 entry/cycle sustained when i_ready=1 (occ holds at 1).
- Occupancy update per edge: occ_next = occ + pop − (o_valid & i_ready). Simultaneous push and pop at occ=1 keeps order.
- Back-pressure with i_ready=0:
  - Buffer fills to 2 entries, then fifo_pop=0.
  - o_data is held stable while o_valid & !i_ready.
- RUN → FLUSH on any edge where i_flush=1:
  - A handshake completing in that same cycle is a valid delivery and is counted as a beat.
  - All remaining buffer entries are discarded at that edge, added to drop count.
- State FLUSH:
  - o_valid=0.
  - fifo_pop = !fifo_empty; each popped entry is discarded and counted as a drop.
- FLUSH → RUN when i_flush=0 and fifo_empty=1.
  - o_flush_done pulses high for the first RUN cycle.
  - If i_flush stays high, the block remains in FLUSH and keeps draining new pushes.
- i_flush asserted while occ=0 and FIFO empty → FLUSH for ≥1 cycle, then done pulse after i_flush drops.
- Counters wrap silently. Counters are not cleared by flush.

Optional Feature:
- Macro FIFO_STREAM_READER_STATS_EN.
- Defined: o_beat_cnt increments per handshake and o_drop_cnt increments per discarded entry. Flush-edge discards of 2 entries increment by 2 in one cycle.
- Undefined: both ports remain present, tied to 0, and no counter flops are synthesised.
- Functional stream behaviour is identical either way.

Decomposition:
- Package mmu_fifo_pkg:
  - typedef enum logic {FSR_RUN, FSR_FLUSH} fsr_state_e
  - localparam FSR_BUF_DEPTH = 2
  - localparam FSR_OCC_W = 2
- Sub-module fsr_skid_buf: 2-entry in-order buffer with push/pop/clear, occ output and head data.
- The top-level holds the FSM, pop logic and counters.

Test Plan:
- Push 0xA0..0xA3 into FIFO, i_ready=1 → fifo_pop high 4 consecutive cycles; o_data 0xA0..0xA3 on consecutive cycles starting 1 cycle after first non-empty; beat_cnt=4.
- FIFO holds 5 entries, i_ready=0 for 6 cycles → exactly 2 pops, o_data=first entry stable, FIFO retains 3; then i_ready=1 → all 5 in order with no gap.
- occ=2, i_ready=1 and i_flush=1 in the same cycle, FIFO holds 3 → head counted as beat; 1 buffered + 3 FIFO dropped (drop_cnt=4); o_valid=0 during flush; o_flush_done single pulse after i_flush falls with FIFO empty.
- i_flush held high while upstream pushes 2 more entries → both popped and dropped, no o_valid; drop_cnt increments by 2.
- i_rst asserted mid-stream with occ=2 → o_valid=0 and fifo_pop=0 immediately (asynchronous); after release, streaming resumes from the next FIFO entry.
- Stats macro undefined, rerun scenario 1 → identical stream; o_beat_cnt=o_drop_cnt=0 throughout.
